// File: rtl/dac_frame_scheduler.sv
`timescale 1ns/1ps
// Arbitrates decimated samples against host config words and serialises each
// winner as a 16-bit MSB-first SPI frame. The optional load strobe is enabled by DAC_FRAME_SCHED_LDAC_EN.
module dac_frame_scheduler #(
  parameter int unsigned SCLK_DIV   = 2,
  parameter int unsigned CS_GAP     = 2,
  parameter logic [3:0]  CMD_SAMPLE = 4'h3
) (
  input  logic        dac_clk,
  input  logic        reset,
  input  logic        sample_strobe,
  input  logic [11:0] sample_data,
  output logic        sample_overrun,
  input  logic        cfg_valid,
  input  logic [15:0] cfg_word,
  output logic        cfg_ready,
  output logic        dac_sclk,
  output logic        dac_sdo,
  output logic        dac_cs,
`ifdef DAC_FRAME_SCHED_LDAC_EN
  output logic        dac_ldac,
`endif
  output logic        busy
);

  localparam int unsigned FRAME_W   = 16;
  localparam int unsigned BIT_W     = 4;
  localparam int unsigned PHASE_MAX = 2 * SCLK_DIV;
  localparam int unsigned CNT_MAX   = (PHASE_MAX > CS_GAP) ? PHASE_MAX : CS_GAP;
  localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [FRAME_W-1:0]   shift_q, shift_d;
  logic                 smp_pend_q, smp_pend_d;
  logic [FRAME_W-1:0]   smp_word_q, smp_word_d;
  logic                 cfg_pend_q, cfg_pend_d;
  logic [FRAME_W-1:0]   cfg_word_q, cfg_word_d;
  logic                 last_cfg_q, last_cfg_d;
  logic                 cs_q, cs_d;
  logic                 sclk_q, sclk_d;
  logic                 sdo_q, sdo_d;
  logic                 busy_q, busy_d;
  logic                 ovr_q, ovr_d;
  logic                 cfg_rdy_q, cfg_rdy_d;
  logic                 grant_smp, grant_cfg;
`ifdef DAC_FRAME_SCHED_LDAC_EN
  logic                 ldac_q, ldac_d;
  logic                 frame_smp_q, frame_smp_d;
`endif

  // Next-state, slot bookkeeping and registered-output computation
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    smp_pend_d = smp_pend_q;
    smp_word_d = smp_word_q;
    cfg_pend_d = cfg_pend_q;
    cfg_word_d = cfg_word_q;
    last_cfg_d = last_cfg_q;
    cs_d       = cs_q;
    sclk_d     = sclk_q;
    sdo_d      = sdo_q;
    busy_d     = busy_q;
    ovr_d      = 1'b0;
    cfg_rdy_d  = cfg_rdy_q;
    grant_smp  = 1'b0;
    grant_cfg  = 1'b0;
`ifdef DAC_FRAME_SCHED_LDAC_EN
    ldac_d      = ldac_q;
    frame_smp_d = frame_smp_q;
`endif

    case (state_q)
      ST_IDLE: begin
        // On a tie the sample wins only if the host went last
        if (smp_pend_q && (!cfg_pend_q || last_cfg_q)) begin
          grant_smp = 1'b1;
        end else if (cfg_pend_q) begin
          grant_cfg = 1'b1;
        end
        if (grant_smp || grant_cfg) begin
          state_d    = ST_SHIFT;
          shift_d    = grant_smp ? smp_word_q : cfg_word_q;
          sdo_d      = shift_d[FRAME_W-1];
          cs_d       = 1'b0;
          sclk_d     = 1'b0;
          busy_d     = 1'b1;
          cnt_d      = '0;
          bit_d      = '0;
          last_cfg_d = grant_cfg;
`ifdef DAC_FRAME_SCHED_LDAC_EN
          frame_smp_d = grant_smp;
`endif
        end
      end

      ST_SHIFT: begin
        if (cnt_q == CNT_W'(PHASE_MAX - 1)) begin
          cnt_d  = '0;
          sclk_d = 1'b0;
          if (bit_q == BIT_W'(FRAME_W - 1)) begin
            state_d = ST_GAP;
            cs_d    = 1'b1;
            sdo_d   = 1'b0;
`ifdef DAC_FRAME_SCHED_LDAC_EN
            ldac_d  = !frame_smp_q;
`endif
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            shift_d = {shift_q[FRAME_W-2:0], 1'b0};
            sdo_d   = shift_q[FRAME_W-2];
          end
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
          sclk_d = (cnt_d >= CNT_W'(SCLK_DIV));
        end
      end

      ST_GAP: begin
        if (cnt_q == CNT_W'(CS_GAP - 1)) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
`ifdef DAC_FRAME_SCHED_LDAC_EN
          ldac_d  = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // A strobe in the grant cycle refills the slot without counting as overrun
    if (grant_smp) smp_pend_d = 1'b0;
    if (sample_strobe) begin
      smp_word_d = {CMD_SAMPLE, sample_data};
      smp_pend_d = 1'b1;
      ovr_d      = smp_pend_q && !grant_smp;
    end

    if (grant_cfg) cfg_pend_d = 1'b0;
    if (cfg_valid && cfg_rdy_q) begin
      cfg_pend_d = 1'b1;
      cfg_word_d = cfg_word;
    end
    cfg_rdy_d = !cfg_pend_d;
  end

  always_ff @(posedge dac_clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      smp_pend_q <= 1'b0;
      smp_word_q <= '0;
      cfg_pend_q <= 1'b0;
      cfg_word_q <= '0;
      last_cfg_q <= 1'b1;
      cs_q       <= 1'b1;
      sclk_q     <= 1'b0;
      sdo_q      <= 1'b0;
      busy_q     <= 1'b0;
      ovr_q      <= 1'b0;
      cfg_rdy_q  <= 1'b1;
`ifdef DAC_FRAME_SCHED_LDAC_EN
      ldac_q      <= 1'b1;
      frame_smp_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      smp_pend_q <= smp_pend_d;
      smp_word_q <= smp_word_d;
      cfg_pend_q <= cfg_pend_d;
      cfg_word_q <= cfg_word_d;
      last_cfg_q <= last_cfg_d;
      cs_q       <= cs_d;
      sclk_q     <= sclk_d;
      sdo_q      <= sdo_d;
      busy_q     <= busy_d;
      ovr_q      <= ovr_d;
      cfg_rdy_q  <= cfg_rdy_d;
`ifdef DAC_FRAME_SCHED_LDAC_EN
      ldac_q      <= ldac_d;
      frame_smp_q <= frame_smp_d;
`endif
    end
  end

  assign sample_overrun = ovr_q;
  assign cfg_ready      = cfg_rdy_q;
  assign dac_sclk       = sclk_q;
  assign dac_sdo        = sdo_q;
  assign dac_cs         = cs_q;
  assign busy           = busy_q;
`ifdef DAC_FRAME_SCHED_LDAC_EN
  assign dac_ldac       = ldac_q;
`endif

endmodule

// File: tb/tb_dac_frame_scheduler.sv
`timescale 1ns/1ps
// Scoreboarded bench: stimulus pushes expected frames, an SPI monitor decodes
// the serial line and compares against the queue.
module tb_dac_frame_scheduler;

  localparam int unsigned SCLK_DIV = 2;
  localparam int unsigned CS_GAP   = 2;

  logic        dac_clk = 1'b0;
  logic        reset = 1'b0;
  logic        sample_strobe = 1'b0;
  logic [11:0] sample_data = '0;
  logic        sample_overrun;
  logic        cfg_valid = 1'b0;
  logic [15:0] cfg_word = '0;
  logic        cfg_ready;
  logic        dac_sclk, dac_sdo, dac_cs, busy;
`ifdef DAC_FRAME_SCHED_LDAC_EN
  logic        dac_ldac;
`endif

  dac_frame_scheduler #(.SCLK_DIV(SCLK_DIV), .CS_GAP(CS_GAP), .CMD_SAMPLE(4'h3)) dut (
    .dac_clk        (dac_clk),
    .reset          (reset),
    .sample_strobe  (sample_strobe),
    .sample_data    (sample_data),
    .sample_overrun (sample_overrun),
    .cfg_valid      (cfg_valid),
    .cfg_word       (cfg_word),
    .cfg_ready      (cfg_ready),
    .dac_sclk       (dac_sclk),
    .dac_sdo        (dac_sdo),
    .dac_cs         (dac_cs),
`ifdef DAC_FRAME_SCHED_LDAC_EN
    .dac_ldac       (dac_ldac),
`endif
    .busy           (busy)
  );

  always #5 dac_clk = ~dac_clk;

  typedef struct packed {
    logic [15:0] word;
    logic        is_smp;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  bit   model_last_cfg = 1'b1;
  int   exp_ovr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor state
  logic        prev_cs = 1'b1, prev_sclk = 1'b0, prev_sdo = 1'b0;
  bit          in_frame = 0, have_gap = 0, sdo_bad = 0, last_smp = 0;
  int          low_cnt = 0, n_rise = 0, gap_cnt = 0, last_gap = 0;
  int          frames_seen = 0, ovr_seen = 0, ldac_low = 0;
  logic [15:0] shreg = '0;
  exp_t        e;

  always @(negedge dac_clk) begin
    if (!reset) begin
      in_frame  = 0;
      have_gap  = 0;
      prev_cs   = 1'b1;
      prev_sclk = 1'b0;
      prev_sdo  = 1'b0;
    end else begin
      if (sample_overrun) ovr_seen++;
      if (!dac_cs && prev_cs) begin
        in_frame = 1;
        low_cnt  = 0;
        n_rise   = 0;
        sdo_bad  = 0;
        shreg    = '0;
        if (have_gap) last_gap = gap_cnt;
        have_gap = 0;
      end
      if (in_frame && !dac_cs) begin
        low_cnt++;
        if (dac_sclk && !prev_sclk) begin
          shreg = {shreg[14:0], dac_sdo};
          n_rise++;
        end else if (dac_sclk && prev_sclk && (dac_sdo !== prev_sdo)) begin
          sdo_bad = 1;
        end
      end
      if (in_frame && dac_cs && !prev_cs) begin
        in_frame = 0;
        frames_seen++;
        check("sclk_end_low", dac_sclk, 0);
        check("cs_low_len", low_cnt, 32 * SCLK_DIV);
        check("sclk_rises", n_rise, 16);
        check("sdo_stable_high", sdo_bad, 0);
        if (sb.size() == 0) begin
          check("unexpected_frame", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          check("frame_word", shreg, e.word);
          last_smp = e.is_smp;
        end
        gap_cnt  = 1;
        have_gap = 1;
        ldac_low = 0;
      end else if (have_gap && dac_cs) begin
        gap_cnt++;
      end
`ifdef DAC_FRAME_SCHED_LDAC_EN
      if (have_gap) begin
        if (!dac_ldac) ldac_low++;
        if (gap_cnt == CS_GAP + 1) check("ldac_low_cycles", ldac_low, last_smp ? CS_GAP : 0);
      end
`endif
      prev_cs   = dac_cs;
      prev_sclk = dac_sclk;
      prev_sdo  = dac_sdo;
    end
  end

  // Stimulus helpers: entered and left on a falling clock edge
  task automatic strobe(input logic [11:0] d);
    sample_strobe = 1'b1;
    sample_data   = d;
    @(negedge dac_clk);
    sample_strobe = 1'b0;
  endtask

  task automatic cfg_send(input logic [15:0] w);
    cfg_valid = 1'b1;
    cfg_word  = w;
    @(negedge dac_clk);
    cfg_valid = 1'b0;
  endtask

  task automatic push_smp(input logic [11:0] d);
    sb.push_back({4'h3, d, 1'b1});
    model_last_cfg = 1'b0;
  endtask

  task automatic push_cfg(input logic [15:0] w);
    sb.push_back({w, 1'b0});
    model_last_cfg = 1'b1;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || busy || !dac_cs) && n < 3000) begin
      @(negedge dac_clk);
      n++;
    end
    check("drain_in_time", n < 3000, 1);
    repeat (2) @(negedge dac_clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int          n, ovr0, fs, k, g;
    bit          c, f_cfg;
    logic [11:0] d, last_d;
    logic [15:0] w;

    repeat (3) @(negedge dac_clk);
    check("rst_cs", dac_cs, 1);
    check("rst_sclk", dac_sclk, 0);
    check("rst_sdo", dac_sdo, 0);
    check("rst_cfg_ready", cfg_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_overrun", sample_overrun, 0);
    reset = 1'b1;
    repeat (2) @(negedge dac_clk);

    // Single sample: latency to chip select and busy duration
    push_smp(12'hA5C);
    sample_strobe = 1'b1;
    sample_data   = 12'hA5C;
    @(negedge dac_clk);
    sample_strobe = 1'b0;
    n = 1;
    while (dac_cs && n < 10) begin
      @(negedge dac_clk);
      n++;
    end
    check("strobe_to_cs", n, 2);
    n = 0;
    while (busy && n < 200) begin
      @(negedge dac_clk);
      n++;
    end
    check("busy_high_cycles", n, 32 * SCLK_DIV + CS_GAP);
    wait_drain();

    // Host word handshake
    check("cfg_ready_idle", cfg_ready, 1);
    push_cfg(16'hF001);
    cfg_send(16'hF001);
    check("cfg_ready_after_accept", cfg_ready, 0);
    @(negedge dac_clk);
    check("cfg_ready_after_grant", cfg_ready, 1);
    check("cfg_frame_started", dac_cs, 0);
    wait_drain();

    // Simultaneous arrival after a host frame: sample goes first
    d = 12'($urandom);
    w = 16'($urandom);
    push_smp(d);
    push_cfg(w);
    sample_strobe = 1'b1; sample_data = d;
    cfg_valid = 1'b1;     cfg_word = w;
    @(negedge dac_clk);
    sample_strobe = 1'b0; cfg_valid = 1'b0;
    wait_drain();
    check("gap_b2b", last_gap, CS_GAP + 1);

    // Overwrite while a frame is in flight
    ovr0 = ovr_seen;
    d = 12'($urandom);
    push_smp(d);
    strobe(d);
    repeat (4) @(negedge dac_clk);
    push_smp(12'h222);
    strobe(12'h111);
    strobe(12'h222);
    wait_drain();
    check("overrun_count", ovr_seen - ovr0, 1);

    // Strobe landing in the grant cycle is queued, not an overrun
    ovr0 = ovr_seen;
    d = 12'($urandom);
    last_d = 12'($urandom);
    push_smp(d);
    push_smp(last_d);
    strobe(d);
    strobe(last_d);
    wait_drain();
    check("grant_cycle_no_overrun", ovr_seen - ovr0, 0);

    // Randomised traffic against the arbitration model
    ovr0 = ovr_seen;
    exp_ovr = 0;
    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          d = 12'($urandom);
          push_smp(d);
          strobe(d);
        end
        1: begin
          w = 16'($urandom);
          push_cfg(w);
          cfg_send(w);
        end
        2: begin
          d = 12'($urandom);
          w = 16'($urandom);
          if (model_last_cfg) begin push_smp(d); push_cfg(w); end
          else                begin push_cfg(w); push_smp(d); end
          sample_strobe = 1'b1; sample_data = d;
          cfg_valid = 1'b1;     cfg_word = w;
          @(negedge dac_clk);
          sample_strobe = 1'b0; cfg_valid = 1'b0;
        end
        default: begin
          f_cfg = 1'($urandom);
          if (f_cfg) begin
            w = 16'($urandom); push_cfg(w); cfg_send(w);
          end else begin
            d = 12'($urandom); push_smp(d); strobe(d);
          end
          repeat (4) @(negedge dac_clk);
          k = $urandom_range(0, 3);
          for (int j = 0; j < k; j++) begin
            last_d = 12'($urandom);
            strobe(last_d);
            g = $urandom_range(0, 3);
            repeat (g) @(negedge dac_clk);
          end
          if (k > 1) exp_ovr += k - 1;
          c = 1'($urandom);
          if (c) begin
            w = 16'($urandom);
            cfg_send(w);
          end
          if (k > 0 && c) begin
            if (f_cfg) begin push_smp(last_d); push_cfg(w); end
            else       begin push_cfg(w); push_smp(last_d); end
          end else if (k > 0) begin
            push_smp(last_d);
          end else if (c) begin
            push_cfg(w);
          end
        end
      endcase
      wait_drain();
    end
    check("random_overruns", ovr_seen - ovr0, exp_ovr);

    // Reset in the middle of a frame with a host word pending
    d = 12'($urandom);
    push_smp(d);
    strobe(d);
    n = 0;
    while (dac_cs && n < 10) begin
      @(negedge dac_clk);
      n++;
    end
    repeat (18) @(negedge dac_clk);
    cfg_send(16'h5A5A);
    @(posedge dac_clk);
    #1 reset = 1'b0;
    #1;
    check("midrst_cs", dac_cs, 1);
    check("midrst_sclk", dac_sclk, 0);
    check("midrst_busy", busy, 0);
    check("midrst_cfg_ready", cfg_ready, 1);
    sb.delete();
    fs = frames_seen;
    repeat (3) @(negedge dac_clk);
    reset = 1'b1;
    repeat (200) @(negedge dac_clk);
    check("no_frame_after_reset", frames_seen, fs);
    check("idle_cs_after_reset", dac_cs, 1);

    d = 12'($urandom);
    push_smp(d);
    strobe(d);
    wait_drain();
    check("frame_after_reset", frames_seen, fs + 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
